// File: rtl/ball_direction_pkg.sv
// ball_direction_pkg: direction/state encodings and per-frame collision flags for ball_direction.
package ball_direction_pkg;

    localparam logic HDIR_RIGHT = 1'b0;
    localparam logic HDIR_LEFT  = 1'b1;
    localparam logic VDIR_DOWN  = 1'b0;
    localparam logic VDIR_UP    = 1'b1;

    localparam logic [0:0] ST_SERVE = 1'b0;
    localparam logic [0:0] ST_PLAY  = 1'b1;

    typedef struct packed {
        logic hit_l;
        logic hit_r;
        logic wall_l;
        logic wall_r;
        logic wall_t;
    } flags_t;

endpackage

// File: rtl/ball_direction_edges.sv
// frame_edge_detect: registers blanking and emits line/frame start and end strobes.
module frame_edge_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_HBlank,
    input  logic i_VBlank,
    output logic line_start,
    output logic line_end,
    output logic frame_start,
    output logic frame_end
);

    logic r_hblank, r_vblank;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_hblank <= 1'b0;
            r_vblank <= 1'b0;
        end else begin
            r_hblank <= i_HBlank;
            r_vblank <= i_VBlank;
        end
    end

    assign line_start  = !i_HBlank && r_hblank;
    assign line_end    = i_HBlank && !r_hblank;
    assign frame_start = !i_VBlank && r_vblank;
    assign frame_end   = i_VBlank && !r_vblank;

endmodule

// File: rtl/ball_direction.sv
// ball_direction: latches ball collisions during the visible frame and commits
// direction, score and serve updates once per frame at VBlank onset.
module ball_direction
    import ball_direction_pkg::*;
#(
    parameter int   p_SERVE_FRAMES = 60,
    parameter logic p_START_HDIR   = 1'b0,
    parameter logic p_START_VDIR   = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_HBlank,
    input  logic i_VBlank,
    input  logic i_Ball_Video,
    input  logic i_LPaddle_Video,
    input  logic i_RPaddle_Video,
    output logic o_HDir,
    output logic o_VDir,
    output logic o_Serve,
    output logic o_Score_L,
    output logic o_Score_R,
    output logic o_Hit
);

    logic       line_start, line_end, frame_start, frame_end;
    logic [0:0] state;
    logic [7:0] count;
    logic       r_ball, first_line, line_ball, prev_line;
    flags_t     flags, flags_nxt;
    logic       visible, play, ball_vis, wall_b;
    logic       bounce_l, bounce_r, walls_ok, score_l, score_r, bounce_t, bounce_b;

    frame_edge_detect u_edges (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_HBlank   (i_HBlank),
        .i_VBlank   (i_VBlank),
        .line_start (line_start),
        .line_end   (line_end),
        .frame_start(frame_start),
        .frame_end  (frame_end)
    );

    assign o_Serve = (state == ST_SERVE);

    always_comb begin
        visible  = !i_HBlank && !i_VBlank;
        play     = (state == ST_PLAY);
        ball_vis = play && visible && i_Ball_Video;
        // a VBlank rise coinciding with an HBlank rise has not copied the last line yet
        wall_b   = play && (line_end ? line_ball : prev_line);
        flags_nxt        = flags;
        flags_nxt.hit_l  = flags.hit_l  || (ball_vis && i_LPaddle_Video);
        flags_nxt.hit_r  = flags.hit_r  || (ball_vis && i_RPaddle_Video);
        flags_nxt.wall_l = flags.wall_l || (ball_vis && line_start);
        flags_nxt.wall_t = flags.wall_t || (ball_vis && (first_line || frame_start));
        flags_nxt.wall_r = flags.wall_r || (play && line_end && r_ball);
        bounce_l = flags_nxt.hit_l && !flags_nxt.hit_r && (o_HDir == HDIR_LEFT);
        bounce_r = flags_nxt.hit_r && !flags_nxt.hit_l && (o_HDir == HDIR_RIGHT);
        walls_ok = !(flags_nxt.hit_l && flags_nxt.hit_r) && !bounce_l && !bounce_r;
        score_r  = walls_ok && flags_nxt.wall_l && !flags_nxt.wall_r;
        score_l  = walls_ok && flags_nxt.wall_r && !flags_nxt.wall_l;
        bounce_t = flags_nxt.wall_t && !wall_b && (o_VDir == VDIR_UP);
        bounce_b = wall_b && !flags_nxt.wall_t && (o_VDir == VDIR_DOWN);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_HDir     <= p_START_HDIR;
            o_VDir     <= p_START_VDIR;
            o_Score_L  <= 1'b0;
            o_Score_R  <= 1'b0;
            o_Hit      <= 1'b0;
            state      <= ST_SERVE;
            count      <= 8'(p_SERVE_FRAMES);
            flags      <= '0;
            r_ball     <= 1'b0;
            first_line <= 1'b0;
            line_ball  <= 1'b0;
            prev_line  <= 1'b0;
        end else begin
            r_ball     <= i_Ball_Video && visible;
            first_line <= frame_start || (first_line && !line_end);
            line_ball  <= play && !line_end && (line_ball || ball_vis);
            prev_line  <= play && !frame_end && (line_end ? line_ball : prev_line);
            o_Score_L  <= 1'b0;
            o_Score_R  <= 1'b0;
            o_Hit      <= 1'b0;
            flags      <= (play && !frame_end) ? flags_nxt : '0;
            if (frame_end && play) begin
                o_HDir    <= bounce_l ? HDIR_RIGHT : bounce_r ? HDIR_LEFT :
                             score_r  ? HDIR_LEFT  : score_l  ? HDIR_RIGHT : o_HDir;
                o_VDir    <= bounce_t ? VDIR_DOWN : bounce_b ? VDIR_UP : o_VDir;
                o_Hit     <= bounce_l || bounce_r || bounce_t || bounce_b;
                o_Score_L <= score_l;
                o_Score_R <= score_r;
                if (score_l || score_r) begin
                    state <= ST_SERVE;
                    count <= 8'(p_SERVE_FRAMES);
                end
            end else if (frame_end) begin
                count <= count - 8'd1;
                state <= (count == 8'd1) ? ST_PLAY : ST_SERVE;
            end
        end
    end

endmodule

// File: tb/tb_ball_direction.sv
// tb_ball_direction: drives a tiny 12x8 raster with directed ball/paddle placements and checks each commit.
module tb_ball_direction;

    localparam int SF = 3;
    localparam int HV = 8, HT = 12, VV = 6, VT = 8;

    logic clk = 1'b0;
    logic rst, hb, vb, ball, lpad, rpad;
    logic hdir, vdir, serve, score_l, score_r, hit;

    always #5 clk = ~clk;

    ball_direction #(.p_SERVE_FRAMES(SF), .p_START_HDIR(1'b0), .p_START_VDIR(1'b0)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_HBlank(hb), .i_VBlank(vb),
        .i_Ball_Video(ball), .i_LPaddle_Video(lpad), .i_RPaddle_Video(rpad),
        .o_HDir(hdir), .o_VDir(vdir), .o_Serve(serve),
        .o_Score_L(score_l), .o_Score_R(score_r), .o_Hit(hit)
    );

    typedef struct {
        int bx, by, bw, lp, rp;
        int e_hdir, e_vdir, e_serve, e_hit, e_sl, e_sr;
    } vec_t;

    int checks = 0, failures = 0;
    int n_hit, n_sl, n_sr, pre_serve, post_serve;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int bx, input int by, input int bw, input int lp, input int rp, input int rst_y);
        n_hit = 0; n_sl = 0; n_sr = 0;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                @(negedge clk);
                n_hit += int'(hit); n_sl += int'(score_l); n_sr += int'(score_r);
                if (y == VV && x == 0) pre_serve = int'(serve);
                if (y == VV && x == 1) post_serve = int'(serve);
                rst  = (y == rst_y && x == 0);
                hb   = (x >= HV);
                vb   = (y >= VV);
                ball = !hb && !vb && y == by && x >= bx && x < bx + bw;
                lpad = !hb && !vb && lp >= 0 && (x == lp || x == lp + 1);
                rpad = !hb && !vb && rp >= 0 && (x == rp || x == rp + 1);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int eh, input int ev, input int es, input int ehit, input int esl, input int esr);
        chk({tag, " hdir"}, int'(hdir), eh);
        chk({tag, " vdir"}, int'(vdir), ev);
        chk({tag, " serve"}, int'(serve), es);
        chk({tag, " hit"}, n_hit, ehit);
        chk({tag, " score_l"}, n_sl, esl);
        chk({tag, " score_r"}, n_sr, esr);
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0, 0, 1, -1, -1, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{7, 5, 1, -1,  6, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{3, 2, 1, -1, -1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{3, 2, 1, -1, -1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 2, 2,  1, -1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{5, 5, 1, -1,  5, 1, 1, 0, 1, 0, 0};
        tbl[6]  = '{1, 2, 2,  1, -1, 0, 1, 0, 1, 0, 0};
        tbl[7]  = '{3, 0, 1, -1, -1, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{7, 3, 1, -1, -1, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{3, 2, 1,  1, -1, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 1, -1, -1, 0, 0, 1, 0, 0, 0};
        tbl[11] = '{3, 2, 1, -1, -1, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 5, 1, -1, -1, 1, 1, 1, 1, 0, 1};
        tbl[13] = '{3, 5, 1, -1, -1, 1, 1, 1, 0, 0, 0};
        tbl[14] = '{3, 2, 1, -1, -1, 1, 1, 1, 0, 0, 0};
        tbl[15] = '{3, 2, 1, -1, -1, 1, 1, 0, 0, 0, 0};

        rst = 1'b1; hb = 1'b1; vb = 1'b1; ball = 1'b0; lpad = 1'b0; rpad = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset hdir", int'(hdir), 0);
        chk("reset vdir", int'(vdir), 0);
        chk("reset serve", int'(serve), 1);
        chk("reset pulses", int'(hit) + int'(score_l) + int'(score_r), 0);

        for (int i = 0; i < 16; i++) begin
            run_frame(tbl[i].bx, tbl[i].by, tbl[i].bw, tbl[i].lp, tbl[i].rp, -1);
            check_frame($sformatf("frame%0d", i), tbl[i].e_hdir, tbl[i].e_vdir, tbl[i].e_serve,
                        tbl[i].e_hit, tbl[i].e_sl, tbl[i].e_sr);
            if (i == 2) begin
                chk("serve before 3rd commit", pre_serve, 1);
                chk("serve after 3rd commit", post_serve, 0);
            end
        end

        // left paddle hit latched, then reset before the commit discards it
        run_frame(1, 2, 2, 1, -1, 4);
        check_frame("reset_mid", 0, 0, 1, 0, 0, 0);
        run_frame(3, 2, 1, -1, -1, -1);
        check_frame("reset_mid+1", 0, 0, 1, 0, 0, 0);
        run_frame(3, 2, 1, -1, -1, -1);
        check_frame("reset_mid+2", 0, 0, 0, 0, 0, 0);
        chk("reset_mid serve edge pre", pre_serve, 1);
        chk("reset_mid serve edge post", post_serve, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
